rvj1_lsu: RTL and testbench

//  Load/store unit of the rvj1 core; responder to the controller's LSU command
//  (lsu_cmd/lsu_ctrl_valid) and driver of lsu_ready. Converts one command into
//  one OBI-style data-bus transaction, aligns stores, sign/zero-extends loads
//  and writes load results to the register file. One transaction outstanding.

---
 rtl/rvj1_defines.sv | 35 +++
 rtl/rvj1_lsu_align.sv | 48 ++++
 rtl/rvj1_lsu.sv | 169 ++++++++++++++++
 tb/tb_rvj1_lsu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvj1_defines.sv
// rvj1 shared definitions: LSU command encodings and access sizes.
package rvj1_defines;

    localparam int XLEN  = 32;
    localparam int RALEN = 5;

    localparam int LSU_WRITE_BIT    = 3;
    localparam int LSU_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [3:0] {
        LSU_LB  = 4'b0000,
        LSU_LH  = 4'b0001,
        LSU_LW  = 4'b0010,
        LSU_LBU = 4'b0100,
        LSU_LHU = 4'b0101,
        LSU_SB  = 4'b1000,
        LSU_SH  = 4'b1001,
        LSU_SW  = 4'b1010
    } lsu_ctrl_e;

    // Size 2'b11 falls through to the word rule.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] lo);
        if (size == BYTE) return 1'b0;
        if (size == HALF) return lo[0];
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/rvj1_lsu_align.sv
// rvj1 LSU lane logic: store byte-enable/replication, load extract/extend.
module rvj1_lsu_align
    import rvj1_defines::*;
(
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo_i)
            2'd0:    rbyte = rdata_i[7:0];
            2'd1:    rbyte = rdata_i[15:8];
            2'd2:    rbyte = rdata_i[23:16];
            default: rbyte = rdata_i[31:24];
        endcase
        rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & rbyte[7]}}, rbyte};
            end
            HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & rhalf[15]}}, rhalf};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/rvj1_lsu.sv
// rvj1 load/store unit: one command -> one OBI-style data-bus transaction,
// with registered writeback and exception pulses.
module rvj1_lsu
    import rvj1_defines::*;
#(
    parameter bit DATA_ALIGN_CHECK = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             ctrl_valid_i,
    output logic             ctrl_ready_o,
    input  logic [3:0]       cmd_i,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [RALEN-1:0] regdest_i,
    output logic             lsu_ready_o,
    output logic             rf_wen_o,
    output logic [RALEN-1:0] rf_waddr_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [XLEN-1:0]  data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [XLEN-1:0]  data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic [XLEN-1:0]  data_rdata_i,
    input  logic             data_err_i,
    output logic             exc_misaligned_o,
    output logic             exc_access_o
);

    localparam logic [1:0] eIDLE = 2'd0;
    localparam logic [1:0] eREQ  = 2'd1;
    localparam logic [1:0] eRESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [RALEN-1:0] regdest_q, regdest_d;
    logic             rf_wen_q, rf_wen_d;
    logic [RALEN-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic             lsu_ready_q, lsu_ready_d;
    logic             exc_mis_q, exc_mis_d;
    logic             exc_acc_q, exc_acc_d;

    logic             idle;
    logic             mis;
    logic [1:0]       al_size;
    logic [1:0]       al_lo;
    logic [3:0]       al_be;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_rdata;

    assign idle = (state_q == eIDLE);

    // Lane logic sees the live command while idle, the latched one after.
    assign al_size = idle ? cmd_i[1:0] : cmd_q[1:0];
    assign al_lo   = idle ? addr_i[1:0] : addr_q[1:0];
    assign mis     = DATA_ALIGN_CHECK
                   && lsu_misaligned(cmd_i[1:0], addr_i[1:0]);

    rvj1_lsu_align u_align (
        .size_i     (al_size),
        .unsigned_i (cmd_q[LSU_UNSIGNED_BIT]),
        .addr_lo_i  (al_lo),
        .wdata_i    (wdata_i),
        .rdata_i    (data_rdata_i),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        regdest_d   = regdest_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_wen_d    = 1'b0;
        lsu_ready_d = 1'b0;
        exc_mis_d   = 1'b0;
        exc_acc_d   = 1'b0;
        case (state_q)
            eIDLE: begin
                if (ctrl_valid_i) begin
                    if (mis) begin
                        exc_mis_d   = 1'b1;
                        lsu_ready_d = ~cmd_i[LSU_WRITE_BIT];
                    end else begin
                        cmd_d     = cmd_i;
                        addr_d    = addr_i;
                        wdata_d   = al_wdata;
                        be_d      = al_be;
                        regdest_d = regdest_i;
                        state_d   = eREQ;
                    end
                end
            end
            eREQ: begin
                if (data_gnt_i) state_d = eRESP;
            end
            eRESP: begin
                if (data_rvalid_i) begin
                    state_d   = eIDLE;
                    exc_acc_d = data_err_i;
                    if (!cmd_q[LSU_WRITE_BIT]) begin
                        lsu_ready_d = 1'b1;
                        rf_wen_d    = ~data_err_i
                                    & (regdest_q != '0);
                        rf_waddr_d  = regdest_q;
                        rf_wdata_d  = al_rdata;
                    end
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= eIDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            regdest_q   <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            lsu_ready_q <= 1'b0;
            exc_mis_q   <= 1'b0;
            exc_acc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            regdest_q   <= regdest_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            lsu_ready_q <= lsu_ready_d;
            exc_mis_q   <= exc_mis_d;
            exc_acc_q   <= exc_acc_d;
        end
    end

    assign ctrl_ready_o     = idle;
    assign data_req_o       = (state_q == eREQ);
    assign data_addr_o      = {addr_q[XLEN-1:2], 2'b00};
    assign data_we_o        = cmd_q[LSU_WRITE_BIT];
    assign data_be_o        = be_q;
    assign data_wdata_o     = wdata_q;
    assign lsu_ready_o      = lsu_ready_q;
    assign rf_wen_o         = rf_wen_q;
    assign rf_waddr_o       = rf_waddr_q;
    assign rf_wdata_o       = rf_wdata_q;
    assign exc_misaligned_o = exc_mis_q;
    assign exc_access_o     = exc_acc_q;

endmodule

// File: tb/tb_rvj1_lsu.sv
// Directed bench for rvj1_lsu: table of load/store vectors plus
// stall, misalignment, bus-error and async-reset sequences.
module tb_rvj1_lsu;
    import rvj1_defines::*;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             ctrl_valid_i = 1'b0;
    logic             ctrl_ready_o;
    logic [3:0]       cmd_i = '0;
    logic [XLEN-1:0]  addr_i = '0;
    logic [XLEN-1:0]  wdata_i = '0;
    logic [RALEN-1:0] regdest_i = '0;
    logic             lsu_ready_o;
    logic             rf_wen_o;
    logic [RALEN-1:0] rf_waddr_o;
    logic [XLEN-1:0]  rf_wdata_o;
    logic             data_req_o;
    logic             data_gnt_i = 1'b0;
    logic [XLEN-1:0]  data_addr_o;
    logic             data_we_o;
    logic [3:0]       data_be_o;
    logic [XLEN-1:0]  data_wdata_o;
    logic             data_rvalid_i = 1'b0;
    logic [XLEN-1:0]  data_rdata_i = '0;
    logic             data_err_i = 1'b0;
    logic             exc_misaligned_o;
    logic             exc_access_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    rvj1_lsu #(.DATA_ALIGN_CHECK(1'b1)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .ctrl_valid_i     (ctrl_valid_i),
        .ctrl_ready_o     (ctrl_ready_o),
        .cmd_i            (cmd_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .regdest_i        (regdest_i),
        .lsu_ready_o      (lsu_ready_o),
        .rf_wen_o         (rf_wen_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .data_err_i       (data_err_i),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_access_o     (exc_access_o)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] rfdata;
        logic        wen;
        logic        rdy;
        logic        acc;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int gdly);
        logic [31:0] ea;
        ea = {v.addr[31:2], 2'b00};
        @(negedge clk_i);
        chk("ready_idle", 32'(ctrl_ready_o), 32'd1);
        ctrl_valid_i = 1'b1;
        cmd_i = v.cmd;
        addr_i = v.addr;
        wdata_i = v.wdata;
        regdest_i = v.rd;
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        cmd_i = LSU_SB;
        addr_i = 32'h4;
        wdata_i = 32'h0;
        chk("req", 32'(data_req_o), 32'd1);
        chk("ready_busy", 32'(ctrl_ready_o), 32'd0);
        chk("lsu_rdy_early", 32'(lsu_ready_o), 32'd0);
        chk("addr", data_addr_o, ea);
        chk("be", 32'(data_be_o), 32'(v.be));
        chk("we", 32'(data_we_o), 32'(v.cmd[3]));
        if (v.cmd[3]) chk("wdata", data_wdata_o, v.bwdata);
        for (int i = 0; i < gdly; i++) begin
            ctrl_valid_i = (i % 2 == 0);
            @(negedge clk_i);
            chk("stall_req", 32'(data_req_o), 32'd1);
            chk("stall_addr", data_addr_o, ea);
            chk("stall_be", 32'(data_be_o), 32'(v.be));
            if (v.cmd[3]) chk("stall_wd", data_wdata_o, v.bwdata);
        end
        ctrl_valid_i = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        chk("req_resp", 32'(data_req_o), 32'd0);
        chk("lsu_rdy_resp", 32'(lsu_ready_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i = v.rdata;
        data_err_i = v.err;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        data_err_i = 1'b0;
        data_rdata_i = 32'h5A5A_5A5A;
        chk("lsu_ready", 32'(lsu_ready_o), 32'(v.rdy));
        chk("rf_wen", 32'(rf_wen_o), 32'(v.wen));
        chk("exc_access", 32'(exc_access_o), 32'(v.acc));
        if (v.wen) begin
            chk("rf_wdata", rf_wdata_o, v.rfdata);
            chk("rf_waddr", 32'(rf_waddr_o), 32'(v.rd));
        end
        @(negedge clk_i);
        chk("lsu_rdy_once", 32'(lsu_ready_o), 32'd0);
        chk("rf_wen_once", 32'(rf_wen_o), 32'd0);
    endtask

    task automatic misal(input logic [3:0] cmd, input logic [31:0] a,
                         input logic rdy);
        @(negedge clk_i);
        ctrl_valid_i = 1'b1;
        cmd_i = cmd;
        addr_i = a;
        regdest_i = 5'd7;
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        chk("mis_exc", 32'(exc_misaligned_o), 32'd1);
        chk("mis_rdy", 32'(lsu_ready_o), 32'(rdy));
        chk("mis_wen", 32'(rf_wen_o), 32'd0);
        chk("mis_req", 32'(data_req_o), 32'd0);
        chk("mis_idle", 32'(ctrl_ready_o), 32'd1);
        @(negedge clk_i);
        chk("mis_exc_off", 32'(exc_misaligned_o), 32'd0);
        chk("mis_rdy_off", 32'(lsu_ready_o), 32'd0);
        chk("mis_req2", 32'(data_req_o), 32'd0);
    endtask

    initial begin
        //      cmd      addr          wdata         rdata         rd    err
        //      be       bwdata        rfdata        wen   rdy   acc
        tv[0]  = '{LSU_LB, 32'h8000_0003, 32'h0, 32'h8012_3456, 5'd5, 1'b0,
                  4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0};
        tv[1]  = '{LSU_LHU, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 5'd6, 1'b0,
                  4'b1100, 32'h0, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{LSU_LH, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 5'd7, 1'b0,
                  4'b1100, 32'h0, 32'hFFFF_BEEF, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{LSU_LBU, 32'h8000_0001, 32'h0, 32'h0000_F200, 5'd8, 1'b0,
                  4'b0010, 32'h0, 32'h0000_00F2, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{LSU_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd31, 1'b0,
                  4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{LSU_LH, 32'h0000_0200, 32'h0, 32'hFFFF_7FFF, 5'd1, 1'b0,
                  4'b0011, 32'h0, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{LSU_SB, 32'h0000_0010, 32'h1234_56A5, 32'h0, 5'd3, 1'b0,
                  4'b0001, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{LSU_SH, 32'h0000_0012, 32'hCAFE_BEEF, 32'h0, 5'd3, 1'b0,
                  4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{LSU_SW, 32'h0000_0020, 32'h0123_4567, 32'h0, 5'd3, 1'b0,
                  4'b1111, 32'h0123_4567, 32'h0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{LSU_LW, 32'h0000_0024, 32'h0, 32'h1111_1111, 5'd0, 1'b0,
                  4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tv[10] = '{LSU_LW, 32'h0000_0028, 32'h0, 32'h2222_2222, 5'd9, 1'b1,
                  4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        tv[11] = '{4'b0011, 32'h0000_0030, 32'h0, 32'h89AB_CDEF, 5'd10,
                  1'b0, 4'b1111, 32'h0, 32'h89AB_CDEF, 1'b1, 1'b1, 1'b0};
        tv[12] = '{4'b0110, 32'h0000_0034, 32'h0, 32'h8000_0001, 5'd11,
                  1'b0, 4'b1111, 32'h0, 32'h8000_0001, 1'b1, 1'b1, 1'b0};

        #1;
        chk("rst_ready", 32'(ctrl_ready_o), 32'd1);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_lsu_rdy", 32'(lsu_ready_o), 32'd0);
        chk("rst_wen", 32'(rf_wen_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_exc", 32'({exc_misaligned_o, exc_access_o}), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 13; i++) run(tv[i], 0);

        // Grant withheld five cycles while the controller pokes valid.
        run(tv[2], 5);
        run(tv[8], 5);

        misal(LSU_LW, 32'h8000_0001, 1'b1);
        misal(LSU_LH, 32'h8000_0003, 1'b1);
        misal(LSU_SH, 32'h0000_0013, 1'b0);
        misal(LSU_SW, 32'h0000_0022, 1'b0);

        // Reset while requesting: request drops before the next edge.
        @(negedge clk_i);
        ctrl_valid_i = 1'b1;
        cmd_i = LSU_LW;
        addr_i = 32'h40;
        regdest_i = 5'd12;
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        chk("ar_req_before", 32'(data_req_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        chk("ar_req_drop", 32'(data_req_o), 32'd0);
        chk("ar_ready", 32'(ctrl_ready_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Reset while awaiting response: late rvalid must be ignored.
        @(negedge clk_i);
        ctrl_valid_i = 1'b1;
        cmd_i = LSU_LW;
        addr_i = 32'h44;
        regdest_i = 5'd13;
        @(negedge clk_i);
        ctrl_valid_i = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        chk("ar2_busy", 32'(ctrl_ready_o), 32'd0);
        #2 rstn_i = 1'b0;
        #1;
        chk("ar2_ready", 32'(ctrl_ready_o), 32'd1);
        chk("ar2_req", 32'(data_req_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("late_rdy", 32'(lsu_ready_o), 32'd0);
        chk("late_wen", 32'(rf_wen_o), 32'd0);
        chk("late_req", 32'(data_req_o), 32'd0);
        chk("late_ready", 32'(ctrl_ready_o), 32'd1);

        // Unit still works after the abandoned transaction.
        run(tv[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
